// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between EXE and WB.
//
// Takes one instruction per EXE handshake, runs an aligned byte/half/word
// load or store on a variable-latency request/ack data-memory port, flags
// misaligned addresses (no access is issued for them) and hands a registered
// result plus exception flags to WB. A cancel from WB flushes the stage. An
// access that has already been issued is still completed before the stage
// accepts anything new.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   exe_*                      instruction fields from EXE (exe_valid qualifies)
//   mem_allowin                MEM can accept an instruction this cycle
//   dm_req/wr/addr/wstrb/wdata data-memory request, held stable until dm_ack
//   dm_ack, dm_rdata           access complete / load word
//   wb_allowin, cancel         WB back-pressure and flush
//   mem_wb_*                   registered fields and exception flags for WB
//   mem_wdest                  destination of the instruction in MEM (0 if none)
module mem_stage #(
  parameter logic [31:0] EXC_NONE_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exe_valid,
  output logic        mem_allowin,
  input  logic [31:0] exe_pc,
  input  logic [31:0] exe_result,
  input  logic [31:0] exe_store_data,
  input  logic [3:0]  exe_mem_op,
  input  logic        exe_load_unsigned,
  input  logic        exe_wen,
  input  logic [4:0]  exe_wdest,
  input  logic        exe_overflow,
  output logic        dm_req,
  output logic        dm_wr,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_wstrb,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  input  logic        wb_allowin,
  input  logic        cancel,
  output logic        mem_wb_valid,
  output logic [31:0] mem_wb_pc,
  output logic [31:0] mem_wb_result,
  output logic        mem_wb_wen,
  output logic [4:0]  mem_wb_wdest,
  output logic        mem_wb_raddr_error,
  output logic        mem_wb_waddr_error,
  output logic        mem_wb_overflow,
  output logic [4:0]  mem_wdest
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, DRAIN} state_t;

  state_t      state_reg, state_next;

  // Stage register
  logic        valid_reg;
  logic [31:0] pc_reg;
  logic [31:0] addr_reg;
  logic [31:0] store_data_reg;
  logic [3:0]  mem_op_reg;
  logic        load_unsigned_reg;
  logic        wen_reg;
  logic [4:0]  wdest_reg;
  logic        overflow_reg;
  logic [31:0] load_data_reg;

  // MEM->WB register
  logic        wb_valid_reg;
  logic [31:0] wb_pc_reg;
  logic [31:0] wb_result_reg;
  logic        wb_wen_reg;
  logic [4:0]  wb_wdest_reg;
  logic        wb_raddr_error_reg;
  logic        wb_waddr_error_reg;
  logic        wb_overflow_reg;

  // size: 0=byte, 1=half, 2/3=word
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = a[0];
      default: misaligned = (a != 2'b00);
    endcase
  endfunction

  logic        is_mem, is_store;
  logic [1:0]  size;
  logic        addr_error, raddr_error, waddr_error;
  logic        mem_go, ready_go, leave, capture, in_mem_go;
  logic [31:0] rdata_shift, load_extract;

  assign is_mem      = mem_op_reg[3];
  assign is_store    = mem_op_reg[2];
  assign size        = mem_op_reg[1:0];
  assign addr_error  = is_mem && misaligned(size, addr_reg[1:0]);
  assign raddr_error = addr_error && !is_store;
  assign waddr_error = addr_error && is_store;
  assign mem_go      = is_mem && !addr_error && !overflow_reg;
  assign ready_go    = valid_reg && (state_reg == DONE || !mem_go);
  assign leave       = ready_go && wb_allowin;

  // An issued access blocks the stage until its ack, even after a cancel.
  assign mem_allowin = (!valid_reg || leave) && (state_reg != REQ) && (state_reg != DRAIN);
  assign capture     = exe_valid && mem_allowin && !cancel;

  // The request starts in the cycle right after capture, so the go decision
  // for the incoming instruction is evaluated on the EXE fields.
  assign in_mem_go = exe_mem_op[3] && !misaligned(exe_mem_op[1:0], exe_result[1:0])
                     && !exe_overflow;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (capture && in_mem_go) state_next = REQ;
      REQ: begin
        if (dm_ack)      state_next = cancel ? IDLE : DONE;
        else if (cancel) state_next = DRAIN;
      end
      DONE: begin
        if (cancel)       state_next = IDLE;
        else if (capture) state_next = in_mem_go ? REQ : IDLE;
        else if (leave)   state_next = IDLE;
      end
      DRAIN: if (dm_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Memory request: driven purely from the stage register so it stays stable.
  assign dm_req  = (state_reg == REQ) || (state_reg == DRAIN);
  assign dm_wr   = is_store;
  assign dm_addr = {addr_reg[31:2], 2'b00};

  always_comb begin
    dm_wstrb = 4'b0000;
    dm_wdata = store_data_reg;
    case (size)
      2'd0: begin
        dm_wstrb = 4'b0001 << addr_reg[1:0];
        dm_wdata = {4{store_data_reg[7:0]}};
      end
      2'd1: begin
        dm_wstrb = 4'b0011 << addr_reg[1:0];
        dm_wdata = {2{store_data_reg[15:0]}};
      end
      default: dm_wstrb = 4'b1111;
    endcase
    if (!is_store) dm_wstrb = 4'b0000;
  end

  // Load alignment: bring the addressed byte/half down to bit 0, then extend.
  assign rdata_shift = dm_rdata >> {addr_reg[1:0], 3'b000};

  always_comb begin
    load_extract = dm_rdata;
    case (size)
      2'd0: load_extract = load_unsigned_reg ? {24'b0, rdata_shift[7:0]}
                                             : {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      2'd1: load_extract = load_unsigned_reg ? {16'b0, rdata_shift[15:0]}
                                             : {{16{rdata_shift[15]}}, rdata_shift[15:0]};
      default: load_extract = dm_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= IDLE;
      valid_reg         <= 1'b0;
      pc_reg            <= 32'b0;
      addr_reg          <= 32'b0;
      store_data_reg    <= 32'b0;
      mem_op_reg        <= 4'b0;
      load_unsigned_reg <= 1'b0;
      wen_reg           <= 1'b0;
      wdest_reg         <= 5'b0;
      overflow_reg      <= 1'b0;
      load_data_reg     <= 32'b0;
    end else begin
      state_reg <= state_next;
      if (cancel)       valid_reg <= 1'b0;
      else if (capture) valid_reg <= 1'b1;
      else if (leave)   valid_reg <= 1'b0;
      if (capture) begin
        pc_reg            <= exe_pc;
        addr_reg          <= exe_result;
        store_data_reg    <= exe_store_data;
        mem_op_reg        <= exe_mem_op;
        load_unsigned_reg <= exe_load_unsigned;
        wen_reg           <= exe_wen;
        wdest_reg         <= exe_wdest;
        overflow_reg      <= exe_overflow;
      end
      if (state_reg == REQ && dm_ack && !is_store) load_data_reg <= load_extract;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_reg       <= 1'b0;
      wb_pc_reg          <= 32'b0;
      wb_result_reg      <= 32'b0;
      wb_wen_reg         <= 1'b0;
      wb_wdest_reg       <= 5'b0;
      wb_raddr_error_reg <= 1'b0;
      wb_waddr_error_reg <= 1'b0;
      wb_overflow_reg    <= 1'b0;
    end else if (cancel) begin
      wb_valid_reg <= 1'b0;
    end else if (leave) begin
      wb_valid_reg       <= 1'b1;
      wb_pc_reg          <= pc_reg;
      wb_result_reg      <= (mem_go && !is_store) ? load_data_reg : addr_reg;
      wb_wen_reg         <= wen_reg && !raddr_error && !overflow_reg;
      wb_wdest_reg       <= wdest_reg;
      wb_raddr_error_reg <= raddr_error;
      wb_waddr_error_reg <= waddr_error;
      wb_overflow_reg    <= overflow_reg;
    end else if (wb_allowin) begin
      wb_valid_reg <= 1'b0;
    end
  end

  assign mem_wb_valid       = wb_valid_reg;
  assign mem_wb_pc          = wb_valid_reg ? wb_pc_reg : EXC_NONE_PC;
  assign mem_wb_result      = wb_result_reg;
  assign mem_wb_wen         = wb_wen_reg;
  assign mem_wb_wdest       = wb_wdest_reg;
  assign mem_wb_raddr_error = wb_raddr_error_reg;
  assign mem_wb_waddr_error = wb_waddr_error_reg;
  assign mem_wb_overflow    = wb_overflow_reg;
  assign mem_wdest          = valid_reg ? wdest_reg : 5'd0;

endmodule
